// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO frame receiver: controller state encoding
// and the bit-counter width helper.
package sipo_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Frame-receiver bus: serial-side controls in, parallel word out with a
// valid/ready handshake plus status.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_en;
    logic             sin;
    logic             pdata_ready;
    logic [WIDTH-1:0] pdata;
    logic             pdata_valid;
    logic             busy;
    logic             start_err;

    modport master (
        output start, bit_en, sin, pdata_ready,
        input  pdata, pdata_valid, busy, start_err
    );

    modport slave (
        input  start, bit_en, sin, pdata_ready,
        output pdata, pdata_valid, busy, start_err
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Plain WIDTH-bit serial-in shift register; direction chosen at elaboration
// so the first bit received lands in bit 0 (LSB_FIRST) or bit WIDTH-1.
module sipo_shift_core #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST) begin
                q <= {sin, q[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], sin};
            end
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame receiver controller: sequences the SIPO core per start pulse, counts
// bit_en-qualified samples and hands completed words to a valid/ready register.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sipo_frame_ctrl_if.slave  bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sipo_frame_ctrl: WIDTH must be within 2..32");
    end

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] pdata_q;
    logic             valid_q;
    logic             err_q;
    logic             shift_en;
    logic             do_load;
    logic             can_load;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .sin      (bus.sin),
        .q        (sh_q)
    );

    // A word may move into the holding register if it is empty or being drained.
    assign can_load = !valid_q || bus.pdata_ready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        do_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.bit_en) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD, S_WAIT: begin
                if (can_load) begin
                    do_load    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_WAIT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && bus.start) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // Holding register: a load wins over a consume, so back-to-back words never bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.start && (state != S_IDLE);
            if (do_load) begin
                pdata_q <= sh_q;
                valid_q <= 1'b1;
            end else if (valid_q && bus.pdata_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.pdata       = pdata_q;
    assign bus.pdata_valid = valid_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.start_err   = err_q;

    a_cnt_range : assert property (@(posedge clk) disable iff (rst)
        bit_cnt <= LAST_BIT);

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (valid_q && !bus.pdata_ready) |=> $stable(pdata_q));

endmodule
